// File: rtl/bht_update_sched_if.sv
// Port bundle between the branch-resolve/fetch side, the BHT array and the update scheduler.
// The scheduler connects through the slave modport; the environment uses master.
interface bht_update_sched_if #(
  parameter int IDX_W = 3
);
  logic             upd_valid;
  logic             upd_clr;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ready;
  logic             flush_req;
  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_idx;
  logic             lookup_grant;
  logic             bht_re;
  logic             bht_we;
  logic [IDX_W-1:0] bht_idx;
  logic [1:0]       bht_wdata;
  logic [1:0]       bht_rdata;
  logic             busy;
  logic             flush_done;

  modport master (
    output upd_valid, upd_clr, upd_idx, upd_taken, flush_req,
           lookup_valid, lookup_idx, bht_rdata,
    input  upd_ready, lookup_grant, bht_re, bht_we, bht_idx, bht_wdata,
           busy, flush_done
  );

  modport slave (
    input  upd_valid, upd_clr, upd_idx, upd_taken, flush_req,
           lookup_valid, lookup_idx, bht_rdata,
    output upd_ready, lookup_grant, bht_re, bht_we, bht_idx, bht_wdata,
           busy, flush_done
  );
endinterface

// File: rtl/bht_update_sched.sv
// Single-port BHT access scheduler: fetch lookups, queued 2-bit counter updates,
// entry clears and whole-table sweeps share one array port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | arbitrate: pending flush, queue head (clear/read) or lookup
// S_UPD_WR | write back saturated counter for the head update, pop it
// S_SWEEP  | write 2'b01 to every entry, one per cycle
module bht_update_sched #(
  parameter int IDX_W      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 4
) (
  input logic              clk,
  input logic              reset,
  bht_update_sched_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = IDX_W + 2;
  localparam int SC_W  = $clog2(STARVE_LIM + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = '1;
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIM);

  typedef enum logic [1:0] {S_IDLE, S_UPD_WR, S_SWEEP} state_t;
  state_t state, state_nx;

  logic [ENT_W-1:0] q_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             flush_pend, flush_again;
  logic [IDX_W-1:0] sweep_idx;
  logic [SC_W-1:0]  starve_cnt;

  logic             empty, full, push, pop, lose;
  logic [ENT_W-1:0] head;
  logic             head_clr, head_taken, head_wins, sweep_last;
  logic [IDX_W-1:0] head_idx;
  logic [1:0]       upd_wdata;

  logic             re_c, we_c, grant_c, done_c, ready_c;
  logic [IDX_W-1:0] idx_c;
  logic [1:0]       wdata_c;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head       = q_mem[rd_ptr[PTR_W-1:0]];
  assign head_clr   = head[ENT_W-1];
  assign head_idx   = head[ENT_W-2:1];
  assign head_taken = head[0];
  assign head_wins  = !empty && (!bus.lookup_valid || (starve_cnt == STARVE_MAX));
  assign sweep_last = (sweep_idx == LAST_IDX);

  always_comb begin
    upd_wdata = bus.bht_rdata;
    if (head_taken) begin
      if (bus.bht_rdata != 2'b11) upd_wdata = bus.bht_rdata + 2'b01;
    end else begin
      if (bus.bht_rdata != 2'b00) upd_wdata = bus.bht_rdata - 2'b01;
    end
  end

  // All outputs are held low while reset is asserted so no partial write escapes.
  assign ready_c = !reset && !full && !flush_pend && !bus.flush_req && (state != S_SWEEP);
  assign push    = bus.upd_valid && ready_c;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (flush_pend)                 state_nx = S_SWEEP;
        else if (head_wins && !head_clr) state_nx = S_UPD_WR;
      end
      S_UPD_WR: state_nx = S_IDLE;
      S_SWEEP:  if (sweep_last) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    re_c    = 1'b0;
    we_c    = 1'b0;
    idx_c   = '0;
    wdata_c = 2'b00;
    grant_c = 1'b0;
    done_c  = 1'b0;
    pop     = 1'b0;
    lose    = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          if (flush_pend) begin
            re_c = 1'b0;
          end else if (head_wins) begin
            idx_c = head_idx;
            if (head_clr) begin
              we_c    = 1'b1;
              wdata_c = 2'b01;
              pop     = 1'b1;
            end else begin
              re_c = 1'b1;
            end
          end else if (bus.lookup_valid) begin
            re_c    = 1'b1;
            idx_c   = bus.lookup_idx;
            grant_c = 1'b1;
            lose    = !empty;
          end
        end
        S_UPD_WR: begin
          we_c    = 1'b1;
          idx_c   = head_idx;
          wdata_c = upd_wdata;
          pop     = 1'b1;
        end
        S_SWEEP: begin
          we_c    = 1'b1;
          idx_c   = sweep_idx;
          wdata_c = 2'b01;
          done_c  = sweep_last;
        end
        default: re_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      flush_pend  <= 1'b1;
      flush_again <= 1'b0;
      sweep_idx   <= '0;
      starve_cnt  <= '0;
    end else if (state == S_IDLE && flush_pend) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      flush_again <= 1'b0;
      sweep_idx   <= '0;
      starve_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (pop)
        starve_cnt <= '0;
      else if (lose && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + SC_W'(1);
      if (state == S_SWEEP) begin
        sweep_idx <= sweep_idx + IDX_W'(1);
        // A flush requested mid-sweep buys one more complete sweep.
        if (sweep_last) begin
          flush_pend  <= flush_again || bus.flush_req;
          flush_again <= 1'b0;
        end else if (bus.flush_req) begin
          flush_again <= 1'b1;
        end
      end else if (bus.flush_req) begin
        flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr[PTR_W-1:0]] <= {bus.upd_clr, bus.upd_idx, bus.upd_taken};
  end

  assign bus.upd_ready    = ready_c;
  assign bus.lookup_grant = grant_c;
  assign bus.bht_re       = re_c;
  assign bus.bht_we       = we_c;
  assign bus.bht_idx      = idx_c;
  assign bus.bht_wdata    = wdata_c;
  assign bus.flush_done   = done_c;
  assign bus.busy         = !reset && ((state != S_IDLE) || !empty || flush_pend);
endmodule
